// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, single-write register file with a same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
// Optional build macro REGFILE_PARITY_EN adds an even-parity bit per
// register and a per-read-port par_err output.
module regfile_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 15,
    parameter int NUM_RD      = 2,
    parameter int PEND_W      = 2,
    parameter int RESET_INDEX = 1,
    parameter int ZERO_R0     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_stall,
    input  logic                     flush,
    output logic                     pend_any
`ifdef REGFILE_PARITY_EN
    ,
    output logic [NUM_RD-1:0]        par_err
`endif
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0] pend [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic wr_ok;
    logic iss_ok;

    // Index exists and is not the hard-wired zero register.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign wr_ok  = wr_en && writable(wr_addr);
    assign iss_ok = iss_en && writable(iss_addr);

    // Issue stall: target counter saturated and not retiring this cycle.
    always_comb begin
        iss_stall = 1'b0;
        if (iss_ok && (pend[iss_addr] == '1) && !(wr_ok && (wr_addr == iss_addr)))
            iss_stall = 1'b1;
    end

    // Per-register increment/decrement requests and the pending summary.
    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        pend_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            dec_vec[i] = wr_ok && (wr_addr == ADDR_W'(i)) && (pend[i] != '0);
            inc_vec[i] = iss_ok && !iss_stall && (iss_addr == ADDR_W'(i));
            if (pend[i] != '0)
                pend_any = 1'b1;
        end
    end

    // Register storage: async reset to index or zero, then writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Pending counters: flush wins; a simultaneous inc and dec cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                pend[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                pend[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    pend[i] <= pend[i] + PEND_W'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    pend[i] <= pend[i] - PEND_W'(1);
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par [NUM_REGS];

    // Parity bit per register, kept in step with the data storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                par[i] <= (RESET_INDEX != 0) ? ^(DATA_W'(i)) : 1'b0;
        end else if (wr_ok) begin
            par[wr_addr] <= ^wr_data;
        end
    end
`endif

    // Read ports: zero for r0/illegal, bypass on matching write, else storage.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              byp;
        rd_data = '0;
        rd_busy = '0;
`ifdef REGFILE_PARITY_EN
        par_err = '0;
`endif
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            a   = rd_addr[k*ADDR_W +: ADDR_W];
            byp = wr_ok && (wr_addr == a);
            if (writable(a)) begin
                rd_data[k*DATA_W +: DATA_W] = byp ? wr_data : regs[a];
                rd_busy[k] = (pend[a] - PEND_W'(dec_vec[a])) != '0;
`ifdef REGFILE_PARITY_EN
                par_err[k] = !byp && ((^regs[a]) != par[a]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [3:0]  iss_addr;
    logic        iss_stall;
    logic        flush;
    logic        pend_any;
`ifdef REGFILE_PARITY_EN
    logic [1:0]  par_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(
        .DATA_W(32), .ADDR_W(4), .NUM_REGS(15), .NUM_RD(2),
        .PEND_W(2), .RESET_INDEX(1), .ZERO_R0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall),
        .flush(flush), .pend_any(pend_any)
`ifdef REGFILE_PARITY_EN
        , .par_err(par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        rd_addr = {4'd3, 4'd14};
        #3;
        check("rst_rd_3_14", rd_data, {32'd3, 32'd14});
        check("rst_pend_any", 64'(pend_any), 64'd0);
        check("rst_iss_stall", 64'(iss_stall), 64'd0);
        check("rst_rd_busy", 64'(rd_busy), 64'd0);
`ifdef REGFILE_PARITY_EN
        check("rst_par_err", 64'(par_err), 64'd0);
`endif
        rd_addr = {4'd0, 4'd15};
        #1;
        check("rst_rd_0_15", rd_data, 64'd0);
        @(negedge clk); rst = 1'b0;

        // same-cycle bypass, then read from storage
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; rd_addr = {4'd6, 4'd5};
        #1 check("bypass5", rd_data, {32'd6, 32'hDEADBEEF});
        @(negedge clk); wr_en = 1'b0;
        #1 check("stored5", rd_data, {32'd6, 32'hDEADBEEF});

        // writes to r0 and out-of-range index
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234; rd_addr = {4'd1, 4'd0};
        #1 check("r0_no_bypass", rd_data, {32'd1, 32'd0});
        @(negedge clk); wr_addr = 4'd15; wr_data = 32'h5555; rd_addr = {4'd0, 4'd15};
        #1 check("r15_read_zero", rd_data, 64'd0);
        @(negedge clk); wr_en = 1'b0; rd_addr = {4'd14, 4'd1};
        #1 check("regs_untouched", rd_data, {32'd14, 32'd1});
        rd_addr = {4'd0, 4'd13};
        #1 check("r0_still_zero", rd_data, {32'd0, 32'd13});

        // saturate reg 7
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); iss_en = 1'b1; iss_addr = 4'd7;
            #1 check("iss7_no_stall", 64'(iss_stall), 64'd0);
        end
        @(negedge clk); rd_addr = {4'd0, 4'd7};
        #1 check("iss7_sat_stall", 64'(iss_stall), 64'd1);
        check("busy7", 64'(rd_busy), 64'd1);
        check("pend_any7", 64'(pend_any), 64'd1);
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
        #1 check("stall_released", 64'(iss_stall), 64'd0);
        check("busy7_during_dec", 64'(rd_busy), 64'd1);
        check("bypass7", rd_data, {32'd0, 32'h77});
        @(negedge clk); wr_en = 1'b0;
        #1 check("inc_dec_same_keep3", 64'(iss_stall), 64'd1);

        // drain reg 7
        iss_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'(i);
            #1 check("drain7_busy", 64'(rd_busy), (i == 2) ? 64'd0 : 64'd1);
        end
        @(negedge clk); // retire on an empty counter
        @(negedge clk); wr_en = 1'b0;
        #1 check("no_wrap", 64'(pend_any), 64'd0);

        // single pending on reg 2 retired while read
        @(negedge clk); iss_en = 1'b1; iss_addr = 4'd2;
        @(negedge clk); iss_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'd22;
        rd_addr = {4'd0, 4'd2};
        #1 check("busy2_retire", 64'(rd_busy), 64'd0);
        check("pend_any_pre", 64'(pend_any), 64'd1);
        @(negedge clk); wr_en = 1'b0;
        #1 check("pend_any_post", 64'(pend_any), 64'd0);

        // flush with concurrent write to reg 4 and issue to reg 9
        @(negedge clk); iss_en = 1'b1; iss_addr = 4'd4;
        @(negedge clk); iss_addr = 4'd9;
        @(negedge clk);
        flush = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hA5A5A5A5;
        rd_addr = {4'd9, 4'd4};
        #1 check("flush_busy_pre", 64'(rd_busy), 64'd2);
        @(negedge clk); flush = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        #1 check("flush_pend_any", 64'(pend_any), 64'd0);
        check("flush_busy", 64'(rd_busy), 64'd0);
        check("flush_write4", rd_data, {32'd9, 32'hA5A5A5A5});

        // issue to illegal / zero index never counts
        @(negedge clk); iss_en = 1'b1; iss_addr = 4'd15;
        #1 check("iss15_no_stall", 64'(iss_stall), 64'd0);
        @(negedge clk); iss_addr = 4'd0;
        @(negedge clk); iss_en = 1'b0;
        #1 check("illegal_iss", 64'(pend_any), 64'd0);

        // inc and dec on different registers in one cycle
        @(negedge clk); iss_en = 1'b1; iss_addr = 4'd3;
        @(negedge clk); iss_addr = 4'd8; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd33;
        @(negedge clk); iss_en = 1'b0; wr_en = 1'b0; rd_addr = {4'd8, 4'd3};
        #1 check("inc_dec_diff", 64'(rd_busy), 64'd2);
        check("write3", rd_data, {32'd8, 32'd33});

        // asynchronous reset mid-cycle
        @(negedge clk); rd_addr = {4'd6, 4'd5};
        #2 rst = 1'b1;
        #1 check("async_rst_data", rd_data, {32'd6, 32'd5});
        check("async_rst_pend", 64'(pend_any), 64'd0);
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'd66;
        @(negedge clk); rst = 1'b0; wr_en = 1'b0;
        #1 check("rst_blocks_write", rd_data, {32'd6, 32'd5});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
